// File: rtl/mips_core_pkg.sv
// Shared types for the MIPS core: hazard FSM states, hazard source encoding
// and register-file constants.
package mips_core_pkg;

    typedef enum logic {
        RUN,
        RECOVER
    } hazard_state_t;

    typedef enum logic [2:0] {
        HZ_NONE,
        HZ_LOAD_USE,
        HZ_IC_MISS,
        HZ_RECOVER,
        HZ_MISPREDICT,
        HZ_DC_MISS
    } hazard_src_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_perf_counters.sv
// Free-running wrap-around performance counters for the hazard sequencer.
// Compiled only when HAZARD_PERF_CNT_EN is defined.
`ifdef HAZARD_PERF_CNT_EN
module hazard_perf_counters #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             bubble,
    input  logic             mispredict,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] bubbles,
    output logic [CNT_W-1:0] mispredicts
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            bubbles      <= '0;
            mispredicts  <= '0;
        end else begin
            if (stall)      stall_cycles <= stall_cycles + 1'b1;
            if (bubble)     bubbles      <= bubbles + 1'b1;
            if (mispredict) mispredicts  <= mispredicts + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/hazard_sequencer.sv
// Central stall/flush controller for the five-stage pipeline: priority-arbitrated
// hazard sources, post-redirect bubble FSM and D-miss watchdog.
// Optional perf counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_sequencer
    import mips_core_pkg::*;
#(
    parameter int unsigned REDIRECT_BUBBLES = 1,
    parameter int unsigned STALL_TIMEOUT    = 1024,
    parameter int unsigned CNT_W            = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ic_miss,
    input  logic             dc_miss,
    input  logic             ex_valid,
    input  logic             ex_mispredict,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rw_addr,
    input  logic             dec_uses_rs,
    input  logic             dec_uses_rt,
    input  logic [4:0]       dec_rs_addr,
    input  logic [4:0]       dec_rt_addr,
    output logic             pc_stall,
    output logic             pc_redirect,
    output logic             f2d_stall,
    output logic             f2d_flush,
    output logic             d2e_stall,
    output logic             d2e_flush,
    output logic             e2m_stall,
    output logic             e2m_flush,
    output logic             m2w_stall,
    output logic             m2w_flush,
    output logic             hang_err,
    output logic [CNT_W-1:0] perf_stall_cycles,
    output logic [CNT_W-1:0] perf_bubbles,
    output logic [CNT_W-1:0] perf_mispredicts
);

    localparam int unsigned WD_W = $clog2(STALL_TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(STALL_TIMEOUT - 1);
    localparam logic [2:0] BUBBLES = 3'(REDIRECT_BUBBLES);

    hazard_state_t   state, state_next;
    hazard_src_t     src;
    logic [2:0]      bcnt, bcnt_next;
    logic [WD_W-1:0] wd_cnt;
    logic            mispredict;
    logic            load_use;

    assign mispredict = ex_valid & ex_mispredict;
    assign load_use   = ex_valid & ex_is_load & (ex_rw_addr != REG_ZERO) &
                        ((dec_uses_rs & (dec_rs_addr == ex_rw_addr)) |
                         (dec_uses_rt & (dec_rt_addr == ex_rw_addr)));

    // Outputs are forced idle while reset is held so the pipeline sees no
    // stray stall/flush from stale inputs.
    always_comb begin
        src = HZ_NONE;
        if (!rst_n)                src = HZ_NONE;
        else if (dc_miss)          src = HZ_DC_MISS;
        else if (mispredict)       src = HZ_MISPREDICT;
        else if (state == RECOVER) src = HZ_RECOVER;
        else if (ic_miss)          src = HZ_IC_MISS;
        else if (load_use)         src = HZ_LOAD_USE;
    end

    always_comb begin
        pc_stall    = 1'b0;
        pc_redirect = 1'b0;
        f2d_stall   = 1'b0;
        f2d_flush   = 1'b0;
        d2e_stall   = 1'b0;
        d2e_flush   = 1'b0;
        e2m_stall   = 1'b0;
        e2m_flush   = 1'b0;
        m2w_stall   = 1'b0;
        m2w_flush   = 1'b0;
        unique case (src)
            HZ_DC_MISS: begin
                pc_stall  = 1'b1;
                f2d_stall = 1'b1;
                d2e_stall = 1'b1;
                e2m_stall = 1'b1;
                m2w_flush = 1'b1;
            end
            HZ_MISPREDICT: begin
                pc_redirect = 1'b1;
                f2d_flush   = 1'b1;
                d2e_flush   = 1'b1;
            end
            HZ_RECOVER: f2d_flush = 1'b1;
            HZ_IC_MISS: begin
                pc_stall  = 1'b1;
                f2d_flush = 1'b1;
            end
            HZ_LOAD_USE: begin
                pc_stall  = 1'b1;
                f2d_stall = 1'b1;
                d2e_flush = 1'b1;
            end
            default: ;
        endcase
    end

    // bcnt is frozen while a D-miss holds the pipeline.
    always_comb begin
        state_next = state;
        bcnt_next  = bcnt;
        unique case (state)
            RUN: begin
                if (src == HZ_MISPREDICT && BUBBLES != 3'd0) begin
                    state_next = RECOVER;
                    bcnt_next  = BUBBLES;
                end
            end
            RECOVER: begin
                if (src == HZ_MISPREDICT) begin
                    bcnt_next = BUBBLES;
                end else if (!dc_miss) begin
                    bcnt_next = bcnt - 3'd1;
                    if (bcnt == 3'd1) state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
            bcnt  <= '0;
        end else begin
            state <= state_next;
            bcnt  <= bcnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt   <= '0;
            hang_err <= 1'b0;
        end else begin
            if (!dc_miss)              wd_cnt <= '0;
            else if (wd_cnt != WD_LAST) wd_cnt <= wd_cnt + 1'b1;
            if (dc_miss && wd_cnt == WD_LAST) hang_err <= 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_counters #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (pc_stall),
        .bubble       (f2d_flush | d2e_flush | e2m_flush | m2w_flush),
        .mispredict   (pc_redirect),
        .stall_cycles (perf_stall_cycles),
        .bubbles      (perf_bubbles),
        .mispredicts  (perf_mispredicts)
    );
`else
    assign perf_stall_cycles = '0;
    assign perf_bubbles      = '0;
    assign perf_mispredicts  = '0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed self-checking bench for hazard_sequencer (REDIRECT_BUBBLES=2, STALL_TIMEOUT=8).
module tb_hazard_sequencer;

    localparam int unsigned CNT_W = 32;

    // {pc_stall, pc_redirect, f2d_stall, f2d_flush, d2e_stall, d2e_flush,
    //  e2m_stall, e2m_flush, m2w_stall, m2w_flush}
    localparam logic [9:0] O_NONE = 10'b0000000000;
    localparam logic [9:0] O_DC   = 10'b1010101001;
    localparam logic [9:0] O_MP   = 10'b0101010000;
    localparam logic [9:0] O_REC  = 10'b0001000000;
    localparam logic [9:0] O_IC   = 10'b1001000000;
    localparam logic [9:0] O_LU   = 10'b1010010000;

    logic clk = 1'b0;
    logic rst_n;
    logic ic_miss, dc_miss, ex_valid, ex_mispredict, ex_is_load;
    logic [4:0] ex_rw_addr, dec_rs_addr, dec_rt_addr;
    logic dec_uses_rs, dec_uses_rt;
    logic pc_stall, pc_redirect, f2d_stall, f2d_flush, d2e_stall, d2e_flush;
    logic e2m_stall, e2m_flush, m2w_stall, m2w_flush, hang_err;
    logic [CNT_W-1:0] perf_stall_cycles, perf_bubbles, perf_mispredicts;
    logic [9:0] outs;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_sequencer #(
        .REDIRECT_BUBBLES(2),
        .STALL_TIMEOUT(8),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ic_miss(ic_miss), .dc_miss(dc_miss),
        .ex_valid(ex_valid), .ex_mispredict(ex_mispredict),
        .ex_is_load(ex_is_load), .ex_rw_addr(ex_rw_addr),
        .dec_uses_rs(dec_uses_rs), .dec_uses_rt(dec_uses_rt),
        .dec_rs_addr(dec_rs_addr), .dec_rt_addr(dec_rt_addr),
        .pc_stall(pc_stall), .pc_redirect(pc_redirect),
        .f2d_stall(f2d_stall), .f2d_flush(f2d_flush),
        .d2e_stall(d2e_stall), .d2e_flush(d2e_flush),
        .e2m_stall(e2m_stall), .e2m_flush(e2m_flush),
        .m2w_stall(m2w_stall), .m2w_flush(m2w_flush),
        .hang_err(hang_err),
        .perf_stall_cycles(perf_stall_cycles),
        .perf_bubbles(perf_bubbles),
        .perf_mispredicts(perf_mispredicts)
    );

    assign outs = {pc_stall, pc_redirect, f2d_stall, f2d_flush, d2e_stall, d2e_flush,
                   e2m_stall, e2m_flush, m2w_stall, m2w_flush};

    typedef struct {
        string      name;
        logic       ic, dc, ev, mp, ld;
        logic [4:0] rw;
        logic       urs;
        logic [4:0] rs;
        logic       urt;
        logic [4:0] rt;
        logic [9:0] exp;
    } vec_t;

    function automatic vec_t mk(input string n, input logic ic, input logic dc,
                                input logic ev, input logic mp, input logic ld,
                                input logic [4:0] rw, input logic urs, input logic [4:0] rs,
                                input logic urt, input logic [4:0] rt, input logic [9:0] e);
        vec_t v;
        v.name = n; v.ic = ic; v.dc = dc; v.ev = ev; v.mp = mp; v.ld = ld;
        v.rw = rw; v.urs = urs; v.rs = rs; v.urt = urt; v.rt = rt; v.exp = e;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        ic_miss = v.ic; dc_miss = v.dc; ex_valid = v.ev; ex_mispredict = v.mp;
        ex_is_load = v.ld; ex_rw_addr = v.rw; dec_uses_rs = v.urs; dec_rs_addr = v.rs;
        dec_uses_rt = v.urt; dec_rt_addr = v.rt;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply inputs for one cycle, check the Mealy outputs, then clock.
    task automatic step(input vec_t v, input string name, input logic [9:0] e);
        drive(v);
        #1;
        chk(name, {22'd0, outs}, {22'd0, e});
        tick();
    endtask

    vec_t idle, mpv, dcv, dcmp, luv;
    vec_t tbl[11];

    initial begin
        idle = mk("idle", 0,0,0,0,0, 5'd0, 0,5'd0, 0,5'd0, O_NONE);
        mpv  = mk("mp",   0,0,1,1,0, 5'd0, 0,5'd0, 0,5'd0, O_MP);
        dcv  = mk("dc",   0,1,0,0,0, 5'd0, 0,5'd0, 0,5'd0, O_DC);
        dcmp = mk("dcmp", 0,1,1,1,0, 5'd0, 0,5'd0, 0,5'd0, O_DC);
        luv  = mk("lu",   0,0,1,0,1, 5'd8, 1,5'd8, 0,5'd0, O_LU);

        tbl[0]  = mk("idle",       0,0,0,0,0, 5'd0,  0,5'd0,  0,5'd0,  O_NONE);
        tbl[1]  = mk("lu_rs",      0,0,1,0,1, 5'd8,  1,5'd8,  0,5'd0,  O_LU);
        tbl[2]  = mk("lu_rt",      0,0,1,0,1, 5'd17, 1,5'd3,  1,5'd17, O_LU);
        tbl[3]  = mk("lu_r0",      0,0,1,0,1, 5'd0,  1,5'd0,  1,5'd0,  O_NONE);
        tbl[4]  = mk("lu_nouse",   0,0,1,0,1, 5'd8,  0,5'd8,  1,5'd9,  O_NONE);
        tbl[5]  = mk("lu_invalid", 0,0,0,0,1, 5'd8,  1,5'd8,  0,5'd0,  O_NONE);
        tbl[6]  = mk("not_load",   0,0,1,0,0, 5'd8,  1,5'd8,  1,5'd8,  O_NONE);
        tbl[7]  = mk("ic_miss",    1,0,0,0,0, 5'd0,  0,5'd0,  0,5'd0,  O_IC);
        tbl[8]  = mk("ic_over_lu", 1,0,1,0,1, 5'd8,  1,5'd8,  0,5'd0,  O_IC);
        tbl[9]  = mk("dc_over_all",1,1,1,0,1, 5'd8,  1,5'd8,  0,5'd0,  O_DC);
        tbl[10] = mk("mp_invalid", 0,0,0,1,0, 5'd0,  0,5'd0,  0,5'd0,  O_NONE);

        // Reset state
        rst_n = 1'b0;
        drive(idle);
        repeat (3) tick();
        chk("reset_outs", {22'd0, outs}, 32'd0);
        chk("reset_hang", {31'd0, hang_err}, 32'd0);
        chk("reset_perf_stall", perf_stall_cycles, 32'd0);
        chk("reset_perf_bub", perf_bubbles, 32'd0);
        chk("reset_perf_mp", perf_mispredicts, 32'd0);
        rst_n = 1'b1;

        foreach (tbl[i]) step(tbl[i], tbl[i].name, tbl[i].exp);

        // Mispredict with two redirect bubbles
        step(mpv,  "mp_c0", O_MP);
        step(idle, "mp_c1", O_REC);
        step(idle, "mp_c2", O_REC);
        step(idle, "mp_c3", O_NONE);

        // Recovery is frozen by dc_miss and outranks a load-use
        step(mpv,  "frz_c0", O_MP);
        step(idle, "frz_c1", O_REC);
        step(dcv,  "frz_dc", O_DC);
        step(luv,  "frz_rec_over_lu", O_REC);
        step(idle, "frz_done", O_NONE);

        // D-miss holds a mispredict until it drops
        for (int c = 0; c < 4; c++) step(dcmp, $sformatf("dcmp_c%0d", c), O_DC);
        step(mpv,  "dcmp_redirect", O_MP);
        step(idle, "dcmp_rec1", O_REC);
        step(idle, "dcmp_rec2", O_REC);
        step(idle, "dcmp_run", O_NONE);

        // Watchdog: an interrupted run must not accumulate
        drive(dcv);
        repeat (5) tick();
        drive(idle);
        tick();
        drive(dcv);
        repeat (7) tick();
        chk("wd_7_cycles", {31'd0, hang_err}, 32'd0);
        tick();
        chk("wd_8_cycles", {31'd0, hang_err}, 32'd1);
        drive(idle);
        repeat (3) tick();
        chk("wd_sticky", {31'd0, hang_err}, 32'd1);
        rst_n = 1'b0;
        tick();
        chk("wd_reset", {31'd0, hang_err}, 32'd0);
        rst_n = 1'b1;

        // Reset in the middle of a recovery discards it
        step(mpv, "rmid_mp", O_MP);
        rst_n = 1'b0;
        step(mpv, "rmid_in_reset", O_NONE);
        rst_n = 1'b1;
        step(idle, "rmid_after", O_NONE);

        // Performance counters from a clean reset
        rst_n = 1'b0;
        drive(idle);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) step(luv, $sformatf("perf_lu%0d", c), O_LU);
        step(mpv,  "perf_mp", O_MP);
        step(idle, "perf_rec1", O_REC);
        step(idle, "perf_rec2", O_REC);
        step(idle, "perf_run", O_NONE);
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_stall_cycles", perf_stall_cycles, 32'd3);
        chk("perf_bubbles", perf_bubbles, 32'd6);
        chk("perf_mispredicts", perf_mispredicts, 32'd1);
`else
        chk("perf_stall_cycles", perf_stall_cycles, 32'd0);
        chk("perf_bubbles", perf_bubbles, 32'd0);
        chk("perf_mispredicts", perf_mispredicts, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
